// File: rtl/fighter_pkg.sv
// fighter_pkg: types and default constants shared by the round/health
// controller, its health channels and its bus interface.
//   round_state_t   - round FSM encoding exported on round_state
//   MAX_HEALTH_DEF  - default refill value at round start
//   IFRAMES_DEF     - default hit-immunity length in frames
package fighter_pkg;

  typedef enum logic [1:0] {
    RS_INTRO      = 2'd0,
    RS_FIGHT      = 2'd1,
    RS_KO         = 2'd2,
    RS_MATCH_OVER = 2'd3
  } round_state_t;

  localparam int MAX_HEALTH_DEF = 200;
  localparam int IFRAMES_DEF    = 30;

endpackage

// File: rtl/round_health_ctrl_if.sv
// round_health_ctrl_if: bus between the hit logic / color mapper side and
// the round/health controller.
//   master: drives frame_tick, hit, damage; receives health, invuln, wins,
//           round_state, round_start, winner, match_over
//   slave : the controller (opposite directions)
interface round_health_ctrl_if
  import fighter_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int HEALTH_W      = 8,
  parameter int ROUNDS_TO_WIN = 2
) ();

  localparam int WIN_W = $clog2(ROUNDS_TO_WIN + 1);
  localparam int IDX_W = $clog2(NUM_PLAYERS);

  logic                                  frame_tick;
  logic [NUM_PLAYERS-1:0]                hit;
  logic [NUM_PLAYERS-1:0][HEALTH_W-1:0]  damage;
  logic [NUM_PLAYERS-1:0][HEALTH_W-1:0]  health;
  logic [NUM_PLAYERS-1:0]                invuln;
  logic [NUM_PLAYERS-1:0][WIN_W-1:0]     wins;
  round_state_t                          round_state;
  logic                                  round_start;
  logic [IDX_W-1:0]                      winner;
  logic                                  match_over;

  modport master (
    output frame_tick, hit, damage,
    input  health, invuln, wins, round_state, round_start, winner, match_over
  );

  modport slave (
    input  frame_tick, hit, damage,
    output health, invuln, wins, round_state, round_start, winner, match_over
  );

endinterface

// File: rtl/health_channel.sv
// health_channel: one fighter's health register with saturating damage
// and a post-hit immunity counter.
//   Clk, Reset  - clock, asynchronous active-high reset
//   hit_en      - hits may be accepted (round is in FIGHT)
//   refill      - restore MAX_HEALTH and clear immunity (next round)
//   frame_tick  - one pulse per frame, decrements immunity
//   hit, damage - hit request and its damage amount
//   health      - current health
//   invuln      - immunity counter is nonzero
module health_channel #(
  parameter int HEALTH_W   = 8,
  parameter int MAX_HEALTH = 200,
  parameter int IFRAMES    = 30
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                hit_en,
  input  logic                refill,
  input  logic                frame_tick,
  input  logic                hit,
  input  logic [HEALTH_W-1:0] damage,
  output logic [HEALTH_W-1:0] health,
  output logic                invuln
);

  localparam int IF_W = (IFRAMES < 1) ? 1 : $clog2(IFRAMES + 1);

  logic [IF_W-1:0] icnt;
  logic            accept;

  function automatic logic [HEALTH_W-1:0] sat_sub(input logic [HEALTH_W-1:0] a,
                                                  input logic [HEALTH_W-1:0] b);
    return (b >= a) ? '0 : a - b;
  endfunction

  assign accept = hit_en && hit && (icnt == '0);
  assign invuln = (icnt != '0);

  // A fresh hit reloads immunity even when a frame tick lands in the same cycle.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      health <= HEALTH_W'(MAX_HEALTH);
      icnt   <= '0;
    end else if (refill) begin
      health <= HEALTH_W'(MAX_HEALTH);
      icnt   <= '0;
    end else if (accept) begin
      health <= sat_sub(health, damage);
      icnt   <= IF_W'(IFRAMES);
    end else if (frame_tick && (icnt != '0)) begin
      icnt   <= icnt - IF_W'(1);
    end
  end

endmodule

// File: rtl/round_health_ctrl.sv
// round_health_ctrl: N-fighter health channels plus best-of-N round FSM.
//   Clk, Reset - clock, asynchronous active-high reset
//   bus.slave  - frame_tick/hit/damage in; health, invuln, wins,
//                round_state, round_start, winner, match_over out
// Round flow: INTRO (INTRO_FRAMES ticks) -> FIGHT (until any health is 0)
// -> KO (KO_HOLD ticks) -> INTRO again, or MATCH_OVER once a player has
// ROUNDS_TO_WIN wins.
module round_health_ctrl
  import fighter_pkg::*;
#(
  parameter int NUM_PLAYERS   = 2,
  parameter int HEALTH_W      = 8,
  parameter int MAX_HEALTH    = MAX_HEALTH_DEF,
  parameter int IFRAMES       = IFRAMES_DEF,
  parameter int INTRO_FRAMES  = 90,
  parameter int KO_HOLD       = 120,
  parameter int ROUNDS_TO_WIN = 2
) (
  input logic               Clk,
  input logic               Reset,
  round_health_ctrl_if.slave bus
);

  localparam int WIN_W   = $clog2(ROUNDS_TO_WIN + 1);
  localparam int IDX_W   = $clog2(NUM_PLAYERS);
  localparam int ALIVE_W = $clog2(NUM_PLAYERS + 1);
  localparam int FC_MAX  = (INTRO_FRAMES > KO_HOLD) ? INTRO_FRAMES : KO_HOLD;
  localparam int FC_W    = $clog2(FC_MAX + 1);

  localparam logic [1:0] ST_INTRO      = 2'(RS_INTRO);
  localparam logic [1:0] ST_FIGHT      = 2'(RS_FIGHT);
  localparam logic [1:0] ST_KO         = 2'(RS_KO);
  localparam logic [1:0] ST_MATCH_OVER = 2'(RS_MATCH_OVER);

  logic [1:0]                           state;
  logic [FC_W-1:0]                      fcnt;
  logic [NUM_PLAYERS-1:0][WIN_W-1:0]    wins_q;
  logic [IDX_W-1:0]                     winner_q;
  logic                                 match_over_q;
  logic                                 round_start_q;

  logic [NUM_PLAYERS-1:0][HEALTH_W-1:0] health;
  logic [NUM_PLAYERS-1:0]               invuln;

  logic                                 hit_en;
  logic                                 refill;
  logic                                 any_dead;
  logic [ALIVE_W-1:0]                   alive_cnt;
  logic [IDX_W-1:0]                     alive_idx;
  logic                                 champ_found;
  logic [IDX_W-1:0]                     champ_idx;
  logic                                 intro_done;
  logic                                 ko_done;

  assign hit_en     = (state == ST_FIGHT);
  assign intro_done = bus.frame_tick && (fcnt == FC_W'(INTRO_FRAMES - 1));
  assign ko_done    = bus.frame_tick && (fcnt == FC_W'(KO_HOLD - 1));
  assign refill     = (state == ST_KO) && ko_done && !champ_found;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_ch
    health_channel #(
      .HEALTH_W   (HEALTH_W),
      .MAX_HEALTH (MAX_HEALTH),
      .IFRAMES    (IFRAMES)
    ) u_ch (
      .Clk        (Clk),
      .Reset      (Reset),
      .hit_en     (hit_en),
      .refill     (refill),
      .frame_tick (bus.frame_tick),
      .hit        (bus.hit[g]),
      .damage     (bus.damage[g]),
      .health     (health[g]),
      .invuln     (invuln[g])
    );
  end

  // Survivor census: alive_idx is only meaningful when exactly one is alive.
  always_comb begin
    any_dead  = 1'b0;
    alive_cnt = '0;
    alive_idx = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) begin
      if (health[i] == '0) begin
        any_dead = 1'b1;
      end else begin
        alive_cnt = alive_cnt + ALIVE_W'(1);
        alive_idx = IDX_W'(i);
      end
    end
  end

  // Lowest index holding ROUNDS_TO_WIN wins takes the match.
  always_comb begin
    champ_found = 1'b0;
    champ_idx   = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (wins_q[i] == WIN_W'(ROUNDS_TO_WIN)) begin
        champ_found = 1'b1;
        champ_idx   = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= ST_INTRO;
      fcnt          <= '0;
      wins_q        <= '0;
      winner_q      <= '0;
      match_over_q  <= 1'b0;
      round_start_q <= 1'b0;
    end else begin
      round_start_q <= 1'b0;
      case (state)
        ST_INTRO: begin
          if (intro_done) begin
            state         <= ST_FIGHT;
            fcnt          <= '0;
            round_start_q <= 1'b1;
          end else if (bus.frame_tick) begin
            fcnt <= fcnt + FC_W'(1);
          end
        end
        ST_FIGHT: begin
          if (any_dead) begin
            state <= ST_KO;
            fcnt  <= '0;
            if ((alive_cnt == ALIVE_W'(1)) &&
                (wins_q[alive_idx] != WIN_W'(ROUNDS_TO_WIN))) begin
              wins_q[alive_idx] <= wins_q[alive_idx] + WIN_W'(1);
            end
          end
        end
        ST_KO: begin
          if (ko_done) begin
            fcnt <= '0;
            if (champ_found) begin
              state        <= ST_MATCH_OVER;
              winner_q     <= champ_idx;
              match_over_q <= 1'b1;
            end else begin
              state <= ST_INTRO;
            end
          end else if (bus.frame_tick) begin
            fcnt <= fcnt + FC_W'(1);
          end
        end
        default: begin
          state <= ST_MATCH_OVER;
        end
      endcase
    end
  end

  assign bus.health      = health;
  assign bus.invuln      = invuln;
  assign bus.wins        = wins_q;
  assign bus.round_state = round_state_t'(state);
  assign bus.round_start = round_start_q;
  assign bus.winner      = winner_q;
  assign bus.match_over  = match_over_q;

endmodule

// File: tb/tb_round_health_ctrl.sv
// tb_round_health_ctrl: bench for round_health_ctrl (2 players, default
// parameters). A behavioural game model tracks health, immunity, wins and
// round phase from the rules and is compared with the DUT every cycle;
// directed table vectors and hand sequences cover the test-plan scenarios.
module tb_round_health_ctrl;
  import fighter_pkg::*;

  localparam int NP   = 2;
  localparam int HW   = 8;
  localparam int MAXH = 200;
  localparam int IFR  = 30;
  localparam int INTR = 90;
  localparam int KOH  = 120;
  localparam int RTW  = 2;

  logic Clk = 1'b0;
  logic Reset;

  round_health_ctrl_if #(.NUM_PLAYERS(NP), .HEALTH_W(HW), .ROUNDS_TO_WIN(RTW)) bus ();

  round_health_ctrl #(
    .NUM_PLAYERS(NP), .HEALTH_W(HW), .MAX_HEALTH(MAXH), .IFRAMES(IFR),
    .INTRO_FRAMES(INTR), .KO_HOLD(KOH), .ROUNDS_TO_WIN(RTW)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int rs_seen = 0;

  // Behavioural game model: phase 0 intro, 1 fight, 2 ko, 3 match over.
  int m_h[NP];
  int m_imm[NP];
  int m_wins[NP];
  int m_phase;
  int m_ticks_seen;
  int m_winner;
  bit m_rs;
  bit m_mo;

  typedef struct {
    logic [1:0] hit;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       tick;
    int         eh0;
    int         eh1;
    logic [1:0] einv;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NP; i++) begin
      m_h[i] = MAXH; m_imm[i] = 0; m_wins[i] = 0;
    end
    m_phase = 0; m_ticks_seen = 0; m_winner = 0; m_rs = 0; m_mo = 0;
  endtask

  task automatic model_step();
    int  nh[NP];
    int  nimm[NP];
    int  dmg;
    int  alive;
    int  survivor;
    bit  tk;
    tk = bus.frame_tick;
    for (int i = 0; i < NP; i++) begin
      nh[i]   = m_h[i];
      nimm[i] = (tk && m_imm[i] > 0) ? m_imm[i] - 1 : m_imm[i];
      if (m_phase == 1 && bus.hit[i] && m_imm[i] == 0) begin
        dmg     = int'(bus.damage[i]);
        nh[i]   = (dmg >= m_h[i]) ? 0 : m_h[i] - dmg;
        nimm[i] = IFR;
      end
    end
    m_rs = 0;
    if (m_phase == 0) begin
      if (tk) begin
        m_ticks_seen++;
        if (m_ticks_seen == INTR) begin
          m_phase = 1; m_ticks_seen = 0; m_rs = 1;
        end
      end
    end else if (m_phase == 1) begin
      alive = 0; survivor = 0;
      for (int i = 0; i < NP; i++)
        if (m_h[i] > 0) begin alive++; survivor = i; end
      if (alive < NP) begin
        if (alive == 1 && m_wins[survivor] < RTW) m_wins[survivor]++;
        m_phase = 2; m_ticks_seen = 0;
      end
    end else if (m_phase == 2) begin
      if (tk) begin
        m_ticks_seen++;
        if (m_ticks_seen == KOH) begin
          m_ticks_seen = 0;
          m_phase = 0;
          for (int i = NP - 1; i >= 0; i--)
            if (m_wins[i] == RTW) begin m_phase = 3; m_winner = i; m_mo = 1; end
          if (m_phase == 0)
            for (int i = 0; i < NP; i++) begin nh[i] = MAXH; nimm[i] = 0; end
        end
      end
    end
    for (int i = 0; i < NP; i++) begin m_h[i] = nh[i]; m_imm[i] = nimm[i]; end
  endtask

  task automatic compare_all();
    bit ok;
    ok = 1;
    for (int i = 0; i < NP; i++)
      if (int'(bus.health[i]) != m_h[i] || bus.invuln[i] != (m_imm[i] != 0) ||
          int'(bus.wins[i]) != m_wins[i]) ok = 0;
    if (int'(bus.round_state) != m_phase || bus.round_start != m_rs ||
        int'(bus.winner) != m_winner || bus.match_over != m_mo) ok = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL model_cycle t=%0t: got h=%0d/%0d inv=%b wins=%0d/%0d st=%0d rs=%b win=%0d mo=%b, required h=%0d/%0d inv=%b%b wins=%0d/%0d st=%0d rs=%b win=%0d mo=%b",
               $time, bus.health[0], bus.health[1], bus.invuln, bus.wins[0], bus.wins[1],
               bus.round_state, bus.round_start, bus.winner, bus.match_over,
               m_h[0], m_h[1], m_imm[1] != 0, m_imm[0] != 0, m_wins[0], m_wins[1],
               m_phase, m_rs, m_winner, m_mo);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    if (Reset) model_reset();
    else model_step();
    #1;
    if (bus.round_start) rs_seen++;
    compare_all();
  endtask

  task automatic idle(input int n);
    bus.hit = '0; bus.frame_tick = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic ticks(input int n);
    bus.hit = '0;
    repeat (n) begin
      bus.frame_tick = 1'b1; cycle();
      bus.frame_tick = 1'b0; cycle();
    end
  endtask

  task automatic hit_pl(input logic [1:0] m, input int d0, input int d1, input logic tk);
    bus.hit = m; bus.damage[0] = 8'(d0); bus.damage[1] = 8'(d1); bus.frame_tick = tk;
    cycle();
    bus.hit = '0; bus.frame_tick = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_health0"}, int'(bus.health[0]), MAXH);
    check({tag, "_health1"}, int'(bus.health[1]), MAXH);
    check({tag, "_invuln"}, int'(bus.invuln), 0);
    check({tag, "_wins"}, int'(bus.wins), 0);
    check({tag, "_state"}, int'(bus.round_state), 0);
    check({tag, "_round_start"}, int'(bus.round_start), 0);
    check({tag, "_winner"}, int'(bus.winner), 0);
    check({tag, "_match_over"}, int'(bus.match_over), 0);
  endtask

  initial begin
    tbl[0] = '{2'b01, 8'd50,  8'd0,   1'b0, 150, 200, 2'b01};
    tbl[1] = '{2'b00, 8'd0,   8'd0,   1'b0, 150, 200, 2'b01};
    tbl[2] = '{2'b01, 8'd50,  8'd0,   1'b0, 150, 200, 2'b01};
    tbl[3] = '{2'b10, 8'd0,   8'd0,   1'b0, 150, 200, 2'b11};
    tbl[4] = '{2'b11, 8'd100, 8'd100, 1'b0, 150, 200, 2'b11};
    tbl[5] = '{2'b00, 8'd0,   8'd0,   1'b1, 150, 200, 2'b11};

    bus.hit = '0; bus.damage = '0; bus.frame_tick = 1'b0;
    Reset = 1'b1;
    model_reset();
    #2;
    check_reset_vals("por");
    cycle(); cycle();
    Reset = 1'b0;

    // Intro to first fight
    rs_seen = 0;
    ticks(INTR);
    check("intro_to_fight", int'(bus.round_state), 1);
    check("round_start_once", rs_seen, 1);
    check("fight_h0", int'(bus.health[0]), MAXH);
    check("fight_h1", int'(bus.health[1]), MAXH);

    // Directed damage / immunity vectors
    for (int k = 0; k < 6; k++) begin
      hit_pl(tbl[k].hit, int'(tbl[k].d0), int'(tbl[k].d1), tbl[k].tick);
      check($sformatf("vec%0d_h0", k), int'(bus.health[0]), tbl[k].eh0);
      check($sformatf("vec%0d_h1", k), int'(bus.health[1]), tbl[k].eh1);
      check($sformatf("vec%0d_inv", k), int'(bus.invuln), int'(tbl[k].einv));
    end

    ticks(10);
    hit_pl(2'b01, 50, 0, 1'b0);
    check("immune_hit_ignored", int'(bus.health[0]), 150);
    ticks(19);
    check("immunity_expired", int'(bus.invuln), 0);
    hit_pl(2'b01, 50, 0, 1'b1);
    check("hit_after_iframes", int'(bus.health[0]), 100);
    ticks(29);
    check("load_beats_tick_still_immune", int'(bus.invuln[0]), 1);
    ticks(1);
    check("load_beats_tick_expired", int'(bus.invuln[0]), 0);

    // KO with player 0 surviving
    hit_pl(2'b10, 0, 180, 1'b0);
    check("p1_to_20", int'(bus.health[1]), 20);
    ticks(30);
    hit_pl(2'b10, 0, 255, 1'b0);
    check("sat_to_zero", int'(bus.health[1]), 0);
    check("ko_not_yet", int'(bus.round_state), 1);
    idle(1);
    check("ko_state", int'(bus.round_state), 2);
    check("ko_wins0", int'(bus.wins[0]), 1);
    ticks(KOH);
    check("ko_to_intro", int'(bus.round_state), 0);
    check("refill_h0", int'(bus.health[0]), MAXH);
    check("refill_h1", int'(bus.health[1]), MAXH);

    // Draw round
    ticks(INTR);
    hit_pl(2'b11, 190, 190, 1'b0);
    check("draw_h0_10", int'(bus.health[0]), 10);
    ticks(30);
    hit_pl(2'b11, 10, 10, 1'b0);
    idle(1);
    check("draw_state", int'(bus.round_state), 2);
    check("draw_wins0", int'(bus.wins[0]), 1);
    check("draw_wins1", int'(bus.wins[1]), 0);
    ticks(KOH);

    // Second win ends the match
    ticks(INTR);
    hit_pl(2'b10, 0, 255, 1'b0);
    idle(1);
    check("win2_wins0", int'(bus.wins[0]), 2);
    ticks(KOH);
    check("match_state", int'(bus.round_state), 3);
    check("match_winner", int'(bus.winner), 0);
    check("match_over", int'(bus.match_over), 1);
    for (int k = 0; k < 40; k++) begin
      bus.hit = 2'($urandom); bus.damage[0] = 8'($urandom); bus.damage[1] = 8'($urandom);
      bus.frame_tick = ($urandom_range(0, 1) == 0);
      cycle();
    end
    bus.hit = '0; bus.frame_tick = 1'b0;
    check("mo_hold_h0", int'(bus.health[0]), MAXH);
    check("mo_hold_h1", int'(bus.health[1]), 0);
    check("mo_hold_state", int'(bus.round_state), 3);

    // Reset during KO hold
    Reset = 1'b1; cycle(); Reset = 1'b0;
    ticks(INTR);
    hit_pl(2'b01, 255, 0, 1'b0);
    idle(1);
    check("ko2_wins1", int'(bus.wins[1]), 1);
    ticks(20);
    Reset = 1'b1;
    #1;
    check_reset_vals("async");
    model_reset();
    cycle();
    Reset = 1'b0;
    idle(3);

    // Randomized play against the model
    for (int k = 0; k < 6000; k++) begin
      bus.hit = '0;
      for (int i = 0; i < NP; i++) begin
        bus.hit[i] = ($urandom_range(0, 3) == 0);
        bus.damage[i] = 8'($urandom_range(0, 255));
      end
      bus.frame_tick = ($urandom_range(0, 2) == 0);
      if ((m_mo && $urandom_range(0, 99) == 0) || $urandom_range(0, 2999) == 0) begin
        Reset = 1'b1; cycle(); Reset = 1'b0;
      end else begin
        cycle();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/round_health_ctrl.md
# round_health_ctrl

Parametrised per-fighter health and round controller for the fighting-game datapath: it replaces the fixed two-instance health bar with N health channels, hit invulnerability windows, saturating damage, KO detection and a best-of-N round state machine. It sits between the punch/hit logic and the color mapper. Hit pulses arrive in; health values, round state and winner go out. It runs on one clock and advances game-time counters on a one-cycle frame tick derived from vertical sync.

## Interface
Parameters:
- NUM_PLAYERS, 2: number of fighter channels (≥2)
- HEALTH_W, 8: health and damage width
- MAX_HEALTH, 200: refill value at every round start (< 2^HEALTH_W)
- IFRAMES, 30: frames of hit immunity after an accepted hit
- INTRO_FRAMES, 90: frames spent in INTRO before FIGHT
- KO_HOLD, 120: frames spent in KO before the next round or match end
- ROUNDS_TO_WIN, 2: round wins that end the match

Ports:
- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high; returns all state to reset values
- frame_tick  in  1  one-cycle pulse per video frame
- hit  in  NUM_PLAYERS  per-player hit request, sampled every Clk
- damage  in  NUM_PLAYERS×HEALTH_W  damage paired with hit[i]
- health  out  NUM_PLAYERS×HEALTH_W  current health per player
- invuln  out  NUM_PLAYERS  1 while player i's immunity counter is nonzero
- wins  out  NUM_PLAYERS×$clog2(ROUNDS_TO_WIN+1)  round wins per player
- round_state  out  2  INTRO=0, FIGHT=1, KO=2, MATCH_OVER=3
- round_start  out  1  one-cycle pulse on every entry to FIGHT
- winner  out  $clog2(NUM_PLAYERS)  match winner index, valid when match_over
- match_over  out  1  high in MATCH_OVER

## Operation
- Reset values: health = MAX_HEALTH for all players; invuln = 0; wins = 0; round_state = INTRO; round_start = 0; winner = 0; match_over = 0; frame counter = 0.
- INTRO: the block counts INTRO_FRAMES frame_ticks, then moves to FIGHT and pulses round_start. Hits are ignored.
- FIGHT: hit[i] is accepted only when player i's immunity counter is 0.
  - An accepted hit sets health[i] to health[i] − damage[i], saturating at 0 (damage ≥ health gives 0).
  - An accepted hit loads the immunity counter with IFRAMES.
  - An accepted hit with damage = 0 still loads IFRAMES.
  - Hits on different players in the same cycle are all applied independently.
- Immunity counters decrement on frame_tick in every state, saturating at 0. They are cleared on round refill.
- KO detect: in FIGHT, when any health is 0, the block enters KO on the next cycle.
  - If exactly one player has nonzero health, that player's wins entry increments (saturating at ROUNDS_TO_WIN).
  - If two or more players are alive, or none is, the round is a draw and no wins change.
- KO: hits are ignored. After KO_HOLD frame_ticks:
  - If any wins entry equals ROUNDS_TO_WIN, the block enters MATCH_OVER, sets winner to that index and asserts match_over.
  - Otherwise all health values refill to MAX_HEALTH, all immunity counters clear, and the block enters INTRO.
- MATCH_OVER is terminal until Reset. Health and wins hold their values.
- The frame counter resets to 0 on every state change.

## Timing
- hit at cycle t → health and invuln updated at t+1.
- Health reaches 0 at t+1 → round_state = KO at t+2. The wins increment is visible at t+2.
- A frame_tick in the same cycle as an accepted hit: the load to IFRAMES wins over the decrement.
- A hit in the same cycle as the FIGHT→KO transition: it is applied if accepted; the KO decision uses health registered at t+1.
- round_start is high for exactly the first FIGHT cycle.
- Reset asserted mid-round: all outputs take their reset values asynchronously. Release resumes in INTRO with frame count 0.

## Structure
- Shared package fighter_pkg holds:
  - the round_state_t enum (INTRO, FIGHT, KO, MATCH_OVER)
  - default constants MAX_HEALTH_DEF and IFRAMES_DEF
- Sub-module health_channel, generated NUM_PLAYERS times. It contains the health register, saturating subtract, immunity counter and accept logic. Inputs are hit_en (FIGHT), refill and frame_tick.
- The top contains the round FSM, frame counter, wins registers and winner encoding.

## Test plan
- Reset, then 90 frame_ticks → round_state goes from INTRO to FIGHT and round_start pulses once; health = {200, 200}.
- In FIGHT, hit[0] with damage 50 → health[0] = 150 and invuln[0] = 1. A second hit 10 frames later → ignored. After 30 ticks, a hit with damage 50 → health[0] = 100.
- health[1] = 20 and a hit with damage 255 → health[1] = 0, KO two cycles after the hit, wins[0] = 1. After 120 ticks → INTRO with both health values at 200.
- Both players at 10 health, simultaneous hits with damage 10 → KO as a draw; wins unchanged.
- Player 0 wins two rounds → MATCH_OVER, winner = 0, match_over = 1. Further ticks and hits change nothing.
- Assert Reset during KO hold → all outputs return to reset values immediately; the bench checks no stale wins remain.
